// File: rtl/fetch_pkg.sv
// Shared fetch-side types and constants, also used by issue/decode.
package fetch_pkg;
  localparam int FQ_XLEN = 32;

  // addi x0, x0, 0
  localparam logic [FQ_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Layout of one fetch queue entry; the main FIFO stores {instr, pc} in this order
  typedef struct packed {
    logic [FQ_XLEN-1:0] instr;
    logic [FQ_XLEN-1:0] pc;
  } fq_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; DEPTH must be a power of two and >= 2.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so push+pop at full is legal
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer control; flush wins over any push or pop in the same cycle
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Entry storage, written only on an accepted push and never reset
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

  // Overflow is a caller bug: the credit scheme upstream must prevent it
  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (!(push && full && !pop));
  end
endmodule

// File: rtl/fetch_queue.sv
// Fetch PC generator, imem request issue with credit control, and instruction queue.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 8,
  parameter int              MAX_OUTST = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            instr_valid_o,
  input  logic            instr_fifo_en
);
  localparam int CW = $clog2(DEPTH);
  localparam int TW = $clog2(MAX_OUTST);
  localparam int OW = $clog2(MAX_OUTST + 1);

  logic [XLEN-1:0]   fetch_pc;
  logic [OW-1:0]     outst;
  logic [OW-1:0]     drop;
  logic              hs;
  logic              rsp;
  logic              keep;

  logic [2*XLEN-1:0] main_head;
  logic              main_full;
  logic              main_empty;
  logic [CW:0]       main_count;

  logic [XLEN-1:0]   tag_head;
  logic              tag_full;
  logic              tag_empty;
  logic [TW:0]       tag_count;

  // Only issue when every outstanding response is guaranteed a queue slot
  assign imem_req_o  = !rst && !redirect_i
                     && (int'(main_count) + int'(outst) < DEPTH)
                     && (int'(outst) < MAX_OUTST);
  assign imem_addr_o = fetch_pc;
  assign hs          = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored
  assign rsp         = imem_rvalid_i && (outst != '0);
  // Responses to requests issued before a redirect are stale and discarded
  assign keep        = rsp && (drop == '0) && !redirect_i;

  sync_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_main_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_i),
    .push  (keep),
    .pop   (instr_fifo_en),
    .wdata ({imem_rdata_i, tag_head}),
    .rdata (main_head),
    .full  (main_full),
    .empty (main_empty),
    .count (main_count)
  );

  // Holds the PC of each live (non-stale) request so its response is tagged correctly
  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_i),
    .push  (hs),
    .pop   (keep),
    .wdata (fetch_pc),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign instr_valid_o = !main_empty;
  assign instr         = main_empty ? XLEN'(NOP_INSTR) : main_head[2*XLEN-1:XLEN];
  assign pc            = main_empty ? '0 : main_head[XLEN-1:0];

  // Fetch PC, in-flight count and stale-response count; redirect has top priority
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
      outst    <= outst - OW'(rsp);
      drop     <= outst - OW'(rsp);
    end else begin
      if (hs) fetch_pc <= fetch_pc + XLEN'(4);
      outst <= outst + OW'(hs) - OW'(rsp);
      if (rsp && (drop != '0)) drop <= drop - OW'(1);
    end
  end

  // Protocol and bookkeeping invariants
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid_i && (outst == '0)));
      assert (drop <= outst);
      assert (int'(tag_count) == int'(outst) - int'(drop));
      assert (!(hs && tag_full));
      assert (!(keep && tag_empty));
      assert (!(keep && main_full && !instr_fifo_en));
    end
  end
endmodule
